uart_tx: RTL and testbench

//  Byte-wide UART transmitter; drives the TXD line (PMODL4) of the USB-serial PMOD.

---
 rtl/uart_tx_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 23 ++
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: parity codes, transmitter FSM states and baud divisor.
package uart_tx_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CTS,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Divisor rounded to nearest so odd clock/baud ratios stay within half a clock.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-clock tick every CLKS_PER_BIT clocks, restartable at a bit boundary.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_restart || (r_count == LAST)) r_count <= '0;
    else                                           r_count <= r_count + 1'b1;
  end

  assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with valid/ready input, optional parity and CTS# flow control.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 12_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic       cts_n,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [2:0]  LAST_STOP    = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  tx_state_e  r_state, w_state_next;
  logic [7:0] r_shift, w_shift_next;
  logic [2:0] r_bit_idx, w_bit_idx_next;
  logic       r_par, w_par_next;
  logic       r_tx, w_tx_next;
  logic       r_busy, r_ready;
  logic [1:0] r_cts_sync;
  logic       w_cts_s, w_accept, w_restart, w_tick;

  always_ff @(posedge clk) begin
    if (reset) r_cts_sync <= '1;
    else       r_cts_sync <= {r_cts_sync[0], cts_n};
  end

  assign w_cts_s  = r_cts_sync[1];
  assign w_accept = data_valid && r_ready;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // An accept with CTS already clear skips WAIT_CTS so back-to-back frames keep a 1-clk gap.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_par_next     = r_par;
    w_tx_next      = r_tx;
    w_restart      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_accept) begin
          w_shift_next = data_in;
          w_par_next   = ^data_in;
          if (!w_cts_s) begin
            w_state_next = S_START;
            w_tx_next    = 1'b0;
            w_restart    = 1'b1;
          end else begin
            w_state_next = S_WAIT_CTS;
          end
        end
      end
      S_WAIT_CTS: begin
        if (!w_cts_s) begin
          w_state_next = S_START;
          w_tx_next    = 1'b0;
          w_restart    = 1'b1;
        end
      end
      S_START: begin
        if (w_tick) begin
          w_state_next   = S_DATA;
          w_tx_next      = r_shift[0];
          w_bit_idx_next = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = '0;
            if (PARITY != PARITY_NONE) begin
              w_state_next = S_PARITY;
              w_tx_next    = (PARITY == PARITY_EVEN) ? r_par : ~r_par;
            end else begin
              w_state_next = S_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_tx_next      = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_next   = S_STOP;
          w_tx_next      = 1'b1;
          w_bit_idx_next = '0;
        end
      end
      S_STOP: begin
        w_tx_next = 1'b1;
        if (w_tick) begin
          if (r_bit_idx == LAST_STOP) w_state_next = S_IDLE;
          else                        w_bit_idx_next = r_bit_idx + 3'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_par     <= w_par_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_ready   <= (w_state_next == S_IDLE);
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign data_ready = r_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parameterisations, frame model built from line-level rules.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int NDUT = 3;

  logic       clk = 1'b0;
  logic       rst   [NDUT];
  logic [7:0] din   [NDUT];
  logic       dv    [NDUT];
  logic       dr    [NDUT];
  logic       ctsn  [NDUT];
  logic       txl   [NDUT];
  logic       bsy   [NDUT];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef bit bitq_t[$];
  typedef struct {
    int         d;
    logic [7:0] data;
    int         par;   // expected parity bit, -1 when the DUT has no parity
    string      nm;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: defaults; dut1: even parity, 2 stop bits; dut2: odd parity, fast rate
  uart_tx u_dut0 (
    .clk(clk), .reset(rst[0]), .data_in(din[0]), .data_valid(dv[0]), .data_ready(dr[0]),
    .cts_n(ctsn[0]), .tx(txl[0]), .busy(bsy[0]));
  uart_tx #(.CLK_FREQ(12_000_000), .BAUD(115200), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(rst[1]), .data_in(din[1]), .data_valid(dv[1]), .data_ready(dr[1]),
    .cts_n(ctsn[1]), .tx(txl[1]), .busy(bsy[1]));
  uart_tx #(.CLK_FREQ(1_000_000), .BAUD(125_000), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(rst[2]), .data_in(din[2]), .data_valid(dv[2]), .data_ready(dr[2]),
    .cts_n(ctsn[2]), .tx(txl[2]), .busy(bsy[2]));

  function automatic int cpb_of(input int d);
    int f, b;
    if (d == 2) begin f = 1_000_000;  b = 125_000; end
    else        begin f = 12_000_000; b = 115_200; end
    return (f + b / 2) / b;
  endfunction

  function automatic int pmode_of(input int d);
    return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
  endfunction

  function automatic int nstop_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // Expected line bits of one frame: start, LSB-first data, optional parity, stop bits.
  function automatic bitq_t frame_bits(input int d, input logic [7:0] b, input int par_ov);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (pmode_of(d) != 0) begin
      int ones;
      bit pb;
      ones = $countones(b);
      pb   = (pmode_of(d) == 2) ? bit'(ones % 2) : bit'(1 - ones % 2);
      if (par_ov >= 0) pb = bit'(par_ov);
      q.push_back(pb);
    end
    for (int s = 0; s < nstop_of(d); s++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] b, input bit hold, input string nm);
    int n;
    n = 0;
    din[d] = b;
    dv[d]  = 1'b1;
    while (dr[d] !== 1'b1 && n < 5000) begin step(); n++; end
    checks++;
    if (dr[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: data_ready never rose within 5000 clk", nm);
      dv[d] = 1'b0;
      return;
    end
    step();
    if (!hold) dv[d] = 1'b0;
    check({nm, "_busy_after_accept"}, 32'(bsy[d]), 32'd1);
    check({nm, "_ready_after_accept"}, 32'(dr[d]), 32'd0);
  endtask

  task automatic wait_fall(input int d, input int bound, input string nm,
                           output int waited, output bit ok);
    waited = 0;
    while (txl[d] !== 1'b0 && waited < bound) begin step(); waited++; end
    checks++;
    ok = (txl[d] === 1'b0);
    if (!ok) begin
      failures++;
      $display("FAIL %s start: tx=%b, required start bit within %0d clk", nm, txl[d], bound);
    end
  endtask

  task automatic check_frame(input int d, input logic [7:0] b, input int par_ov,
                             input int fall_bound, input string nm);
    bitq_t q;
    int    bad, waited;
    bit    ok;
    q = frame_bits(d, b, par_ov);
    wait_fall(d, fall_bound, nm, waited, ok);
    if (!ok) return;
    for (int k = 0; k < q.size(); k++) begin
      bad = 0;
      for (int c = 0; c < cpb_of(d); c++) begin
        if (k != 0 || c != 0) step();
        if (txl[d] !== q[k]) bad++;
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s bit%0d: tx wrong on %0d of %0d clk, required %0b",
                 nm, k, bad, cpb_of(d), q[k]);
      end
    end
  endtask

  task automatic check_idle(input int d, input string nm);
    int n;
    step();
    n = 1;
    while (bsy[d] !== 1'b0 && n < 2) begin step(); n++; end
    check({nm, "_busy_end"}, 32'(bsy[d]), 32'd0);
    check({nm, "_ready_end"}, 32'(dr[d]), 32'd1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NDUT; i++) begin
      rst[i] = 1'b1; dv[i] = 1'b0; din[i] = 8'h00; ctsn[i] = 1'b0;
    end
    dv[0]  = 1'b1;
    din[0] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_tx", 32'(txl[0]), 32'd1);
      check("reset_ready", 32'(dr[0]), 32'd0);
      check("reset_busy", 32'(bsy[0]), 32'd0);
    end
    for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;
    step();
    check("release_ready", 32'(dr[0]), 32'd1);
    check("release_tx", 32'(txl[0]), 32'd1);
    dv[0] = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_latency();
    int n0, d;
    send(0, 8'hA5, 1'b0, "a5");
    n0 = cyc;
    check_frame(0, 8'hA5, -1, 1, "a5");
    d = 0;
    while (bsy[0] !== 1'b0 && d < 1100) begin step(); d++; end
    d = cyc - n0;
    checks++;
    if (d < 1040 || d > 1041 || dr[0] !== 1'b1) begin
      failures++;
      $display("FAIL a5_done: idle after %0d clk ready=%b, required 1040..1041 and ready=1", d, dr[0]);
    end
  endtask

  task automatic test_cts();
    int n_hi;
    ctsn[0] = 1'b1;
    repeat (3) step();
    send(0, 8'h55, 1'b0, "cts55");
    n_hi = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (txl[0] === 1'b1 && bsy[0] === 1'b1) n_hi++;
    end
    check("cts_hold_high_busy", 32'(n_hi), 32'd300);
    ctsn[0] = 1'b0;
    fork
      begin repeat (400) @(posedge clk); ctsn[0] = 1'b1; end
    join_none
    check_frame(0, 8'h55, -1, 3, "cts55");
    check_idle(0, "cts55");
    ctsn[0] = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_b2b();
    send(0, 8'h00, 1'b1, "b2b00");
    din[0] = 8'hFF;
    fork
      begin
        repeat (300) @(posedge clk);
        din[0] = 8'h5A;
        repeat (100) @(posedge clk);
        din[0] = 8'hFF;
      end
      begin
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (n < 3000) begin
          @(posedge clk); #1; n++;
          if (dr[0] === 1'b1) seen = 1'b1;
          else if (seen) break;
        end
        dv[0] = 1'b0;
      end
    join_none
    check_frame(0, 8'h00, -1, 1, "b2b00");
    check_frame(0, 8'hFF, -1, 2, "b2bff");
    check_idle(0, "b2bff");
  endtask

  task automatic test_mid_reset();
    int  waited;
    bit  ok;
    send(0, 8'h81, 1'b0, "rst81");
    wait_fall(0, 1, "rst81", waited, ok);
    repeat (5 * 104 + 50) step();
    check("rst81_bit4_low", 32'(txl[0]), 32'd0);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    check("midrst_tx", 32'(txl[0]), 32'd1);
    check("midrst_busy", 32'(bsy[0]), 32'd0);
    step();
    send(0, 8'h42, 1'b0, "post42");
    check_frame(0, 8'h42, -1, 4, "post42");
    check_idle(0, "post42");
  endtask

  initial begin
    vec_t vecs[$];
    vecs.push_back('{d: 1, data: 8'h07, par: 1,  nm: "even07"});
    vecs.push_back('{d: 2, data: 8'h07, par: 0,  nm: "odd07"});
    vecs.push_back('{d: 1, data: 8'h00, par: 0,  nm: "even00"});
    vecs.push_back('{d: 2, data: 8'h00, par: 1,  nm: "odd00"});
    vecs.push_back('{d: 2, data: 8'h80, par: 0,  nm: "odd80"});
    vecs.push_back('{d: 2, data: 8'hFF, par: 1,  nm: "oddff"});
    vecs.push_back('{d: 0, data: 8'h3C, par: -1, nm: "none3c"});

    test_reset();
    test_latency();
    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].data, 1'b0, vecs[i].nm);
      check_frame(vecs[i].d, vecs[i].data, vecs[i].par, 4, vecs[i].nm);
      check_idle(vecs[i].d, vecs[i].nm);
    end
    test_cts();
    test_b2b();
    test_mid_reset();

    for (int r = 0; r < 24; r++) begin
      int         d;
      logic [7:0] b;
      d = (r % 6 == 5) ? 1 : 2;
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) step();
      send(d, b, 1'b0, "rand");
      check_frame(d, b, -1, 4, "rand");
      check_idle(d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
